// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse scheduler: state encoding, counter width,
// default pulse widths and a helper that turns a width into a counter load.
package pulse_pkg;

    localparam int CNT_W = 4;

    localparam int DEF_W0 = 1;
    localparam int DEF_W1 = 3;
    localparam int DEF_W2 = 6;
    localparam int DEF_W3 = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Counter load for an n-cycle phase: the counter runs n-1 .. 0.
    // A width of 0 (or less) is treated as 1, giving a load of 0.
    function automatic logic [CNT_W-1:0] dec_load(input int n);
        if (n <= 1) begin
            return '0;
        end
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin picker: the first asserted request found when scanning
// upward from ptr (wrapping) wins. Purely combinational.
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] winner,
    output logic       valid
);

    logic [1:0] idx;

    // Scan from farthest to nearest so the request closest to ptr wins.
    always_comb begin
        winner = 2'd0;
        valid  = 1'b0;
        idx    = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pulse_scheduler.sv
// Shared-output pulse scheduler. Four requesters compete round-robin for a
// single pulse line; the winner gets a pulse of its own width, a done strobe
// when the pulse ends, and the line then rests for GAP cycles.
//
// Handshake: req is a level request sampled only while idle with enable=1.
// A grant is a commitment: once grant rises the pulse runs its full width and
// done strobes for one cycle afterwards, whatever req does meanwhile. Only
// reset can abort a pulse, and it does so without a done strobe.
module pulse_scheduler
    import pulse_pkg::*;
#(
    parameter int W0  = DEF_W0,
    parameter int W1  = DEF_W1,
    parameter int W2  = DEF_W2,
    parameter int W3  = DEF_W3,
    parameter int GAP = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] req,
    output logic       signal,
    output logic [3:0] grant,
    output logic [3:0] done,
    output logic       busy,
    output logic [1:0] fsm_state
);

    localparam logic [CNT_W-1:0] LOAD0    = dec_load(W0);
    localparam logic [CNT_W-1:0] LOAD1    = dec_load(W1);
    localparam logic [CNT_W-1:0] LOAD2    = dec_load(W2);
    localparam logic [CNT_W-1:0] LOAD3    = dec_load(W3);
    localparam logic [CNT_W-1:0] GAP_LOAD = dec_load(GAP);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       ptr_q;
    logic [1:0]       ptr_d;
    logic             signal_d;
    logic [3:0]       grant_d;
    logic [3:0]       done_d;

    logic [1:0]       arb_winner;
    logic             arb_valid;
    logic [CNT_W-1:0] load_sel;

    rr_arbiter4 u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    // Counter load for whichever requester is about to win.
    always_comb begin
        load_sel = LOAD0;
        case (arb_winner)
            2'd0:    load_sel = LOAD0;
            2'd1:    load_sel = LOAD1;
            2'd2:    load_sel = LOAD2;
            default: load_sel = LOAD3;
        endcase
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        signal_d = signal;
        grant_d  = grant;
        done_d   = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                if (enable && arb_valid) begin
                    state_d  = ST_PULSE;
                    grant_d  = 4'b0001 << arb_winner;
                    signal_d = 1'b1;
                    cnt_d    = load_sel;
                    ptr_d    = arb_winner + 2'd1;
                end
            end
            ST_PULSE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    signal_d = 1'b0;
                    grant_d  = 4'b0000;
                    done_d   = grant;
                    if (GAP > 0) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                signal_d = 1'b0;
                grant_d  = 4'b0000;
            end
        endcase
    end

    // State and output registers; reset overrides everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= 2'd0;
            signal  <= 1'b0;
            grant   <= 4'b0000;
            done    <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            signal  <= signal_d;
            grant   <= grant_d;
            done    <= done_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign fsm_state = state_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Bench for pulse_scheduler with default parameters (widths 1/3/6/12, GAP=1).
// The reference model tracks each pulse as "cycles since grant": the line is
// high for t < W, done strobes at t == W, and the block stays busy while
// t < W + GAP. A new grant is possible only once the previous pulse is over.
module tb_pulse_scheduler;

    // ---------------- clock / reset ----------------
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       signal;
    logic [3:0] grant;
    logic [3:0] done;
    logic       busy;
    logic [1:0] fsm_state;

    always #5 clock = ~clock;

    pulse_scheduler dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .req       (req),
        .signal    (signal),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int total_checks = 0;
    int passed_checks = 0;
    logic [3:0] exp_q[$];
    int         wid_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) passed_checks++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    localparam int GAPV = 1;
    int wid[4] = '{1, 3, 6, 12};
    bit         m_active = 0;
    int         m_t = 0;
    int         m_owner = 0;
    int         m_ptr = 0;
    logic [3:0] m_done = 4'b0000;

    function automatic int eff_w(input int o);
        return (wid[o] < 1) ? 1 : wid[o];
    endfunction

    task automatic model_edge();
        bit found;
        m_done = 4'b0000;
        if (reset) begin
            m_active = 0;
            m_ptr    = 0;
        end else if (m_active) begin
            m_t++;
            if (m_t == eff_w(m_owner)) m_done = 4'(1 << m_owner);
            if (m_t >= eff_w(m_owner) + GAPV) m_active = 0;
        end else if (enable && req != 4'b0000) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && req[(m_ptr + k) % 4]) begin
                    found   = 1;
                    m_owner = (m_ptr + k) % 4;
                end
            end
            m_ptr    = (m_owner + 1) % 4;
            m_active = 1;
            m_t      = 0;
        end
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later.
    task automatic step();
        logic       e_sig;
        logic [3:0] e_gnt;
        @(posedge clock);
        model_edge();
        #1;
        e_sig = m_active && (m_t < eff_w(m_owner));
        e_gnt = e_sig ? 4'(1 << m_owner) : 4'b0000;
        check("signal", signal, e_sig);
        check("grant", grant, e_gnt);
        check("done", done, m_done);
        check("busy", busy, m_active);
        check("grant_onehot0", $onehot0(grant), 1);
    endtask

    task automatic drain();
        req = 4'b0000;
        for (int i = 0; i < 40 && busy; i++) step();
        check("drain_idle", busy, 0);
    endtask

    // ---------------- directed + random stimulus ----------------
    int run;
    int highs;
    int dones;
    logic [3:0] prev_grant;

    initial begin
        // Reset with all requests pending: everything stays 0.
        reset = 1'b1; req = 4'b1111; enable = 1'b1;
        repeat (3) step();
        check("rst_signal", signal, 0);
        check("rst_grant", grant, 0);
        reset = 1'b0;
        step();
        check("first_grant", grant, 4'b0001);
        check("first_signal", signal, 1);
        step();
        check("first_done", done, 4'b0001);

        // Round-robin order and pulse widths with all requests held.
        exp_q = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        wid_q = '{3, 6, 12, 1};
        run = 0;
        prev_grant = grant;
        for (int i = 0; i < 80 && (exp_q.size() != 0 || wid_q.size() != 0); i++) begin
            step();
            if (grant != 4'b0000 && prev_grant == 4'b0000 && exp_q.size() != 0)
                check("rr_order", grant, exp_q.pop_front());
            prev_grant = grant;
            if (signal) run++;
            else if (run > 0) begin
                if (wid_q.size() != 0) check("pulse_width", run, wid_q.pop_front());
                run = 0;
            end
        end
        check("rr_order_all_seen", exp_q.size(), 0);
        check("widths_all_seen", wid_q.size(), 0);
        drain();

        // Reset in the 4th cycle of a requester-2 pulse.
        reset = 1'b1; step(); reset = 1'b0;
        req = 4'b0100;
        step();
        check("r2_grant", grant, 4'b0100);
        repeat (3) step();
        reset = 1'b1;
        step();
        check("abort_signal", signal, 0);
        check("abort_grant", grant, 0);
        check("abort_no_done", done, 0);
        reset = 1'b0; req = 4'b1111;
        step();
        check("post_abort_grant", grant, 4'b0001);
        drain();

        // enable low blocks grants, first enabled edge grants.
        reset = 1'b1; step(); reset = 1'b0;
        enable = 1'b0; req = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            step();
            check("enable_low_no_grant", grant, 0);
        end
        enable = 1'b1;
        step();
        check("enable_grant", grant, 4'b0010);
        drain();

        // Request dropped mid-pulse: full width and done still happen.
        req = 4'b0100;
        step();
        check("drop_grant", grant, 4'b0100);
        highs = 1; dones = 0;
        step(); highs += signal;
        req = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            step();
            highs += signal;
            if (done == 4'b0100) dones++;
        end
        check("drop_width", highs, 6);
        check("drop_done_count", dones, 1);
        drain();

        // Requester 3 alone: 12-cycle pulse, single done, then idle.
        req = 4'b1000;
        step();
        check("r3_grant", grant, 4'b1000);
        req = 4'b0000;
        highs = 1; dones = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            highs += signal;
            if (done == 4'b1000) dones++;
        end
        check("r3_width", highs, 12);
        check("r3_done_count", dones, 1);
        check("r3_idle", busy, 0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            req    = 4'($urandom_range(0, 15));
            enable = ($urandom_range(0, 7) != 0);
            reset  = ($urandom_range(0, 59) == 0);
            step();
        end
        reset = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
